// File: rtl/psk_signal_conditioner.sv
// PSK signal conditioner: stream select/combine, MSB-align with 2^shift gain, settling blanking.
// Optional macro PSK_SIGNAL_COND_SAT_EN selects saturating range reduction (default: wrap, sat_flag = 0).
module psk_signal_conditioner #(
    parameter int I_WIDTH    = 12,
    parameter int O_WIDTH    = 16,
    parameter int SHIFT_W    = 3,
    parameter int SETTLE_CYC = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic signed [I_WIDTH-1:0] DAC_I,
    input  logic signed [I_WIDTH-1:0] DAC_Q,
    input  logic                      is_bpsk,
    input  logic        [1:0]         strm_sel,
    input  logic        [SHIFT_W-1:0] shift,
    output logic                      out_valid,
    output logic signed [O_WIDTH-1:0] PSK_signal,
    output logic                      is_bpsk_out,
    output logic                      settling,
    output logic                      sat_flag
);

    // Valid semantics: a sample is transferred on every clk edge where in_valid is high; there is
    // no backpressure. out_valid marks the matching output exactly two edges later.

    localparam int GAIN_BASE = O_WIDTH - I_WIDTH;
    localparam int CNT_W     = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC);

    // Stage 1 state
    logic                      s1_valid;
    logic signed [I_WIDTH-1:0] s1_sel;
    logic                      s1_bpsk;
    logic        [SHIFT_W-1:0] s1_shift;
    logic                      s1_blank;

    // Change detection state
    logic [CNT_W-1:0] settle_cnt;
    logic             prev_mode;
    logic [1:0]       prev_sel;
    logic             primed;

    // Stage 1 combinational
    logic signed [I_WIDTH:0]   sum_w;
    logic signed [I_WIDTH:0]   dif_w;
    logic signed [I_WIDTH-1:0] sel_val;
    logic                      mode_change;
    logic [CNT_W-1:0]          cnt_next;
    logic                      blank_next;

    always_comb begin
        sum_w = {DAC_I[I_WIDTH-1], DAC_I} + {DAC_Q[I_WIDTH-1], DAC_Q};
        dif_w = {DAC_I[I_WIDTH-1], DAC_I} - {DAC_Q[I_WIDTH-1], DAC_Q};
        unique case (strm_sel)
            2'd0:    sel_val = DAC_I;
            2'd1:    sel_val = DAC_Q;
            // Dropping the LSB of the widened result is a floor divide by two.
            2'd2:    sel_val = sum_w[I_WIDTH:1];
            default: sel_val = dif_w[I_WIDTH:1];
        endcase
    end

    always_comb begin
        mode_change = (is_bpsk != prev_mode) || (strm_sel != prev_sel);
        if (mode_change && primed) begin
            cnt_next = SETTLE_LOAD;
        end else if (settle_cnt != '0) begin
            cnt_next = settle_cnt - 1'b1;
        end else begin
            cnt_next = '0;
        end
        blank_next = (cnt_next != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_sel     <= '0;
            s1_bpsk    <= 1'b0;
            s1_shift   <= '0;
            s1_blank   <= 1'b0;
            settle_cnt <= '0;
            prev_mode  <= 1'b0;
            prev_sel   <= 2'd0;
            primed     <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sel     <= sel_val;
                s1_bpsk    <= is_bpsk;
                s1_shift   <= shift;
                s1_blank   <= blank_next;
                settle_cnt <= cnt_next;
                prev_mode  <= is_bpsk;
                prev_sel   <= strm_sel;
                primed     <= 1'b1;
            end
        end
    end

    // Stage 2 combinational: gain and range reduction
    logic [O_WIDTH-1:0] data_c;
    logic               sat_c;

`ifdef PSK_SIGNAL_COND_SAT_EN
    localparam int V_W = O_WIDTH + 2**SHIFT_W;
    localparam logic signed [V_W-1:0] MAX_V = V_W'((2**(O_WIDTH-1)) - 1);
    localparam logic signed [V_W-1:0] MIN_V = -V_W'(2**(O_WIDTH-1));

    logic signed [V_W-1:0] v;

    always_comb begin
        v = V_W'(s1_sel);
        v = v <<< GAIN_BASE;
        v = v <<< s1_shift;
        if (v > MAX_V) begin
            data_c = {1'b0, {(O_WIDTH-1){1'b1}}};
            sat_c  = 1'b1;
        end else if (v < MIN_V) begin
            data_c = {1'b1, {(O_WIDTH-1){1'b0}}};
            sat_c  = 1'b1;
        end else begin
            data_c = v[O_WIDTH-1:0];
            sat_c  = 1'b0;
        end
    end
`else
    // Wrap keeps only the low O_WIDTH bits, so the product is formed at that width directly.
    logic signed [O_WIDTH-1:0] v_low;

    always_comb begin
        v_low  = O_WIDTH'(s1_sel);
        v_low  = v_low <<< GAIN_BASE;
        v_low  = v_low <<< s1_shift;
        data_c = v_low;
        sat_c  = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            PSK_signal  <= '0;
            is_bpsk_out <= 1'b0;
            settling    <= 1'b0;
            sat_flag    <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                PSK_signal  <= s1_blank ? '0 : data_c;
                sat_flag    <= sat_c & ~s1_blank;
                settling    <= s1_blank;
                is_bpsk_out <= s1_bpsk;
            end
        end
    end

endmodule

// File: tb/tb_psk_signal_conditioner.sv
// Self-checking bench for psk_signal_conditioner: sample-level model plus directed literal checks.
// Honours PSK_SIGNAL_COND_SAT_EN the same way as the design.
module tb_psk_signal_conditioner;
    localparam int IW = 12;
    localparam int OW = 16;
    localparam int SW = 3;
    localparam int SC = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [IW-1:0] dac_i;
    logic [IW-1:0] dac_q;
    logic          is_bpsk;
    logic [1:0]    strm_sel;
    logic [SW-1:0] shift;
    logic          out_valid;
    logic [OW-1:0] psk_signal;
    logic          is_bpsk_out;
    logic          settling;
    logic          sat_flag;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    bit log_en   = 1'b0;
    logic          obs_settle[$];
    logic [OW-1:0] obs_data[$];

    always #5 clk = ~clk;

    psk_signal_conditioner #(
        .I_WIDTH(IW), .O_WIDTH(OW), .SHIFT_W(SW), .SETTLE_CYC(SC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .DAC_I(dac_i), .DAC_Q(dac_q), .is_bpsk(is_bpsk),
        .strm_sel(strm_sel), .shift(shift),
        .out_valid(out_valid), .PSK_signal(psk_signal),
        .is_bpsk_out(is_bpsk_out), .settling(settling), .sat_flag(sat_flag)
    );

    // ---------------- model ----------------
    typedef struct packed {
        logic          valid;
        logic [OW-1:0] data;
        logic          bpsk;
        logic          settle;
        logic          sat;
    } exp_t;

    exp_t e1 = '0;
    exp_t e2 = '0;
    bit   m_primed    = 1'b0;
    bit   m_prev_mode = 1'b0;
    int   m_prev_sel  = 0;
    int   m_remaining = 0;

    function automatic exp_t model_sample(int i, int q, bit b, int sel, int sh);
        exp_t        r;
        longint      sv;
        longint      v;
        logic [63:0] vb;
        bit          blank;
        r = '0;
        r.valid = 1'b1;
        r.bpsk  = b;
        if (m_primed && (b != m_prev_mode || sel != m_prev_sel)) m_remaining = SC;
        blank = (m_remaining > 0);
        if (blank) m_remaining--;
        m_primed    = 1'b1;
        m_prev_mode = b;
        m_prev_sel  = sel;
        case (sel)
            0:       sv = i;
            1:       sv = q;
            2:       sv = (i + q) >>> 1;
            default: sv = (i - q) >>> 1;
        endcase
        v = sv * (longint'(1) << (OW - IW + sh));
`ifdef PSK_SIGNAL_COND_SAT_EN
        if (v > 32767) begin
            v = 32767;
            r.sat = 1'b1;
        end else if (v < -32768) begin
            v = -32768;
            r.sat = 1'b1;
        end
`endif
        vb = v;
        r.data = vb[OW-1:0];
        if (blank) begin
            r.data = '0;
            r.sat  = 1'b0;
        end
        r.settle = blank;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1 = '0;
            e2 = '0;
            m_primed = 1'b0;
            m_prev_mode = 1'b0;
            m_prev_sel = 0;
            m_remaining = 0;
        end else begin
            e2 = e1;
            if (in_valid)
                e1 = model_sample(int'($signed(dac_i)), int'($signed(dac_q)), is_bpsk,
                                  int'(strm_sel), int'(shift));
            else
                e1 = '0;
        end
    end

    // ---------------- checking ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 32'(out_valid), 32'(e2.valid));
            if (e2.valid) begin
                check("PSK_signal", 32'(psk_signal), 32'(e2.data));
                check("settling", 32'(settling), 32'(e2.settle));
                check("is_bpsk_out", 32'(is_bpsk_out), 32'(e2.bpsk));
                check("sat_flag", 32'(sat_flag), 32'(e2.sat));
            end
            if (log_en && out_valid) begin
                obs_settle.push_back(settling);
                obs_data.push_back(psk_signal);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(int i, int q, bit b, int sel, int sh);
        in_valid = 1'b1;
        dac_i    = IW'(i);
        dac_q    = IW'(q);
        is_bpsk  = b;
        strm_sel = 2'(sel);
        shift    = SW'(sh);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic lit(string name, logic [OW-1:0] data, bit settle, bit sat, bit bpsk);
        check({name, ".out_valid"}, 32'(out_valid), 32'd1);
        check({name, ".data"}, 32'(psk_signal), 32'(data));
        check({name, ".settling"}, 32'(settling), 32'(settle));
        check({name, ".sat_flag"}, 32'(sat_flag), 32'(sat));
        check({name, ".is_bpsk_out"}, 32'(is_bpsk_out), 32'(bpsk));
    endtask

    task automatic check_zero_outputs(string name);
        check({name, ".out_valid"}, 32'(out_valid), 32'd0);
        check({name, ".data"}, 32'(psk_signal), 32'd0);
        check({name, ".settling"}, 32'(settling), 32'd0);
        check({name, ".sat_flag"}, 32'(sat_flag), 32'd0);
        check({name, ".is_bpsk_out"}, 32'(is_bpsk_out), 32'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("reset_async");
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_blank;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        dac_i    = '0;
        dac_q    = '0;
        is_bpsk  = 1'b0;
        strm_sel = 2'd0;
        shift    = '0;
        @(negedge clk);
        do_reset();
        chk_en = 1'b1;
        check_zero_outputs("after_reset");

        // I mode, full-scale positive, no gain
        send(12'h7FF, 0, 1'b0, 0, 0);
        idle();
        lit("i_fullscale", 16'h7FF0, 1'b0, 1'b0, 1'b0);

        // Q and combine modes; each select change blanks the first 8 samples
        for (int s = 1; s <= 3; s++) begin
            for (int k = 0; k < 10; k++) send(100, -50, 1'b0, s, 0);
            idle();
            case (s)
                1:       lit("sel_q", 16'hFCE0, 1'b0, 1'b0, 1'b0);
                2:       lit("sel_sum", 16'd400, 1'b0, 1'b0, 1'b0);
                default: lit("sel_dif", 16'd1200, 1'b0, 1'b0, 1'b0);
            endcase
        end

        // Gain and range reduction
        do_reset();
        send(1000, 0, 1'b0, 0, 4);
        idle();
`ifdef PSK_SIGNAL_COND_SAT_EN
        lit("gain_pos", 16'h7FFF, 1'b0, 1'b1, 1'b0);
`else
        lit("gain_pos", 16'hE800, 1'b0, 1'b0, 1'b0);
`endif
        send(-2048, 0, 1'b0, 0, 1);
        idle();
`ifdef PSK_SIGNAL_COND_SAT_EN
        lit("gain_neg", 16'h8000, 1'b0, 1'b1, 1'b0);
`else
        lit("gain_neg", 16'h0000, 1'b0, 1'b0, 1'b0);
`endif

        // Mode toggle on a continuous stream: samples 2..9 blanked, sample 10 passes
        for (int k = 0; k < 12; k++) begin
            send(300, 0, (k >= 2), 0, 0);
            if (k == 9)  lit("settle_last", 16'd0, 1'b1, 1'b0, 1'b1);
            if (k == 11) lit("settle_done", 16'd4800, 1'b0, 1'b0, 1'b1);
        end
        idle();
        idle();

        // Retrigger at the 5th blanked sample with in_valid gaps
        log_en = 1'b1;
        for (int j = 0; j < 20; j++) begin
            send(200, 100, 1'b0, (j >= 4) ? 2 : 0, 0);
            if (j % 3 == 1) idle();
        end
        idle();
        idle();
        log_en = 1'b0;
        check("retrig.count", 32'(obs_settle.size()), 32'd20);
        n_blank = 0;
        foreach (obs_settle[x]) if (obs_settle[x] === 1'b1) n_blank++;
        check("retrig.blanked", 32'(n_blank), 32'd12);
        if (obs_settle.size() >= 13) begin
            check("retrig.last_blank", 32'(obs_settle[11]), 32'd1);
            check("retrig.first_data", 32'(obs_settle[12]), 32'd0);
            check("retrig.first_value", 32'(obs_data[12]), 32'd2400);
        end

        // Reset while settling, then first sample with is_bpsk = 1 is not blanked
        for (int k = 0; k < 3; k++) send(200, 100, 1'b1, 2, 0);
        check("pre_reset.settling", 32'(settling), 32'd1);
        do_reset();
        send(50, 0, 1'b1, 0, 0);
        idle();
        lit("post_reset", 16'd800, 1'b0, 1'b0, 1'b1);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psk_signal_conditioner.md
# psk_signal_conditioner

Parametrised successor to the PSK DAC-to-baseband width extender; sits between the PSK modulator DAC outputs and the downstream carrier-sync/demodulation input. Selects or combines the I/Q streams at runtime, MSB-aligns and applies a programmable power-of-two gain with saturation. Blanks the output for a settling window after a modulation-mode or stream change. Two-stage pipeline with a valid strobe; `is_bpsk` is delay-matched to the data.

## Interface
- `I_WIDTH`, 12, input sample width (signed).
- `O_WIDTH`, 16, output sample width (signed); must be ≥ `I_WIDTH`.
- `SHIFT_W`, 3, width of gain-shift control.
- `SETTLE_CYC`, 8, blanked valid samples after a mode or stream change; must be ≥ 1.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input sample strobe.
- `DAC_I`  in  `I_WIDTH`  signed I sample.
- `DAC_Q`  in  `I_WIDTH`  signed Q sample.
- `is_bpsk`  in  1  modulation mode, sampled with `in_valid`.
- `strm_sel`  in  2  stream select: 0 = I, 1 = Q, 2 = (I+Q)>>>1, 3 = (I−Q)>>>1.
- `shift`  in  `SHIFT_W`  extra left shift (gain 2^shift).
- `out_valid`  out  1  output sample strobe.
- `PSK_signal`  out  `O_WIDTH`  signed conditioned sample.
- `is_bpsk_out`  out  1  `is_bpsk` aligned with `PSK_signal`.
- `settling`  out  1  high while the output is blanked.
- `sat_flag`  out  1  output sample was clipped.

## Operation
- Stage 1, on `in_valid`:
  - Compute `sel_val` (`I_WIDTH` bits). Combine modes use an `I_WIDTH+1` intermediate, then arithmetic right shift by 1 (floor); the result always fits `I_WIDTH`.
  - Register `sel_val`, `is_bpsk`, `shift` and the blank decision.
- Change detection, on `in_valid`:
  - Compare `is_bpsk` and `strm_sel` against registered `prev_mode` / `prev_sel`.
  - Any difference, with `primed` = 1, loads `settle_cnt` = `SETTLE_CYC`.
  - Otherwise a nonzero `settle_cnt` decrements by 1.
  - `prev_*` update every valid sample. `primed` sets on the first valid sample after reset, so that sample never triggers settling.
- Blank decision: a sample is blanked iff `settle_cnt` after the update is nonzero. The triggering sample is therefore blanked, and exactly `SETTLE_CYC` valid samples are blanked.
- A change during settling reloads the counter to `SETTLE_CYC` (no accumulation).
- Stage 2:
  - Compute `v = sext(sel_val) · 2^(O_WIDTH−I_WIDTH+shift)` at width `O_WIDTH+2^SHIFT_W`.
  - Range-reduce per Configuration.
  - A blanked sample outputs 0 with `sat_flag` = 0.
- With `shift` = 0, the output equals `{sel_val, zeros}`, which never clips.
- `in_valid` low: the pipeline holds, `out_valid` deasserts, and counters and `prev_*` are unchanged.
- Reset mid-stream discards in-flight samples. Settling state is lost, and `primed` clears.

## Timing
- Latency 2 cycles: `in_valid` at edge n gives `out_valid`, `PSK_signal`, `is_bpsk_out`, `settling` and `sat_flag` at edge n+2.
- Throughput: one sample per cycle. No backpressure.
- `strm_sel`, `is_bpsk` and `shift` are sampled only on valid cycles.
- Reset values: all outputs 0, `settle_cnt` 0, `prev_mode` 0, `prev_sel` 0, `primed` 0, pipeline registers 0.

## Configuration
- `PSK_SIGNAL_COND_SAT_EN` defined: `v` is clamped to [−2^(O_WIDTH−1), 2^(O_WIDTH−1)−1], and `sat_flag` = 1 when the clamp is active.
- Not defined: `v` is truncated to its low `O_WIDTH` bits (two's-complement wrap), and `sat_flag` is tied to 0.

## Test plan
- Reset then I mode: `DAC_I` = 12'h7FF, `shift` = 0, valid at edge 1 → edge 3 `PSK_signal` = 16'h7FF0, `out_valid` = 1, `settling` = 0.
- Q and combine modes: I = 100, Q = −50, steady `strm_sel` → sel 1: −800; sel 2: 25·16 = 400; sel 3: 75·16 = 1200, each 2 cycles after input.
- Gain and saturation (macro on): I = 1000, `shift` = 4 → 16000·16 exceeds range → 16'h7FFF, `sat_flag` = 1. I = −2048, `shift` = 1 → 16'h8000, `sat_flag` = 1. Macro off, same inputs → wrapped low 16 bits, `sat_flag` = 0.
- Settling: after priming, toggle `is_bpsk` on a continuous valid stream → the next 8 outputs are 0 with `settling` = 1 and `is_bpsk_out` tracking the new mode; the 9th output is non-zero data.
- Retrigger and gaps: change `strm_sel` at blanked sample 5, insert `in_valid` gaps → 8 further valid samples blanked counted from the change, gap cycles keep `out_valid` = 0.
- Async reset asserted mid-settle → all outputs 0 immediately. After release, a first sample with `is_bpsk` = 1 is not blanked.
